// File: rtl/ibex_mem_responder.sv
// ibex_mem_responder
//
// Responder end of the Ibex req/gnt/rvalid memory protocol. Requests are
// backed by a word-addressed SRAM whose 33rd bit carries a capability tag.
// Responses return in grant order, RespLatency cycles after the grant. An
// in-order FIFO of MaxOutstanding entries bounds the transactions in flight.
//
// Optional feature: define MEM_RESP_STALL_EN to enable pseudo-random grant
// stalls from an 8-bit Fibonacci LFSR (taps 8,6,5,4) seeded with StallSeed.
// Without the macro the responder never stalls and the LFSR is not built.
//
// Ports:
//   clk_i     clock, all state on the rising edge
//   rst_i     asynchronous active-high reset (memory contents are kept)
//   req_i     request valid
//   gnt_o     request accepted this cycle (combinational)
//   we_i      1 = write, 0 = read
//   be_i      byte enables (writes only)
//   addr_i    byte address
//   wdata_i   write data, bit 32 = tag
//   rvalid_o  response valid, one cycle per response
//   rdata_o   read data, bit 32 = tag, 0 when rvalid_o is low
//   err_o     error response, qualified by rvalid_o

module ibex_mem_responder #(
   parameter int unsigned Depth          = 1024,
   parameter logic [31:0] BaseAddr       = 32'h8000_0000,
   parameter int unsigned MaxOutstanding = 2,
   parameter int unsigned RespLatency    = 1,
   parameter logic [7:0]  StallSeed      = 8'hA5
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   output logic        gnt_o,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] addr_i,
   input  logic [32:0] wdata_i,
   output logic        rvalid_o,
   output logic [32:0] rdata_o,
   output logic        err_o
);

   localparam int unsigned IdxW = $clog2(Depth);
   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
   localparam int unsigned AgeW = $clog2(RespLatency + 1);

   localparam logic [32:0]     SpanBytes = 33'(Depth) << 2;
   localparam logic [CntW-1:0] MaxCnt    = CntW'(MaxOutstanding);
   localparam logic [AgeW-1:0] AgeDone   = AgeW'(RespLatency);

   if (StallSeed == 8'h00 || MaxOutstanding == 0 || MaxOutstanding > 4 ||
       RespLatency == 0 || RespLatency > 7 || Depth < 2 ||
       (Depth & (Depth - 1)) != 0) begin : g_param_err
      $error("ibex_mem_responder: illegal parameter value");
   end

   // ------------------------------------------------------------------
   // Grant stall source
   // ------------------------------------------------------------------
   logic stall;

`ifdef MEM_RESP_STALL_EN
   logic [7:0] lfsr_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lfsr_q <= StallSeed;
      end else begin
         lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      end
   end

   assign stall = (lfsr_q[1:0] == 2'b00);
`else
   assign stall = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------
   logic [31:0]     offset;
   logic            in_range;
   logic [IdxW-1:0] idx;

   assign offset   = addr_i - BaseAddr;
   // Offset compare is done in 33 bits so a window touching 2^32 cannot wrap.
   assign in_range = (addr_i >= BaseAddr) && ({1'b0, offset} < SpanBytes) &&
                     (addr_i[1:0] == 2'b00);
   assign idx      = offset[IdxW+1:2];

   // ------------------------------------------------------------------
   // Response FIFO (entry 0 is the head)
   // ------------------------------------------------------------------
   logic [32:0]     fifo_rdata_q [MaxOutstanding];
   logic            fifo_err_q   [MaxOutstanding];
   logic [AgeW-1:0] fifo_age_q   [MaxOutstanding];
   logic [32:0]     fifo_rdata_d [MaxOutstanding];
   logic            fifo_err_d   [MaxOutstanding];
   logic [AgeW-1:0] fifo_age_d   [MaxOutstanding];
   logic [AgeW-1:0] aged         [MaxOutstanding];
   logic [CntW-1:0] count_q;
   logic [CntW-1:0] count_d;
   logic [CntW-1:0] wr_pos;

   logic        pop;
   logic        push;
   logic [32:0] push_rdata;
   logic        push_err;
   logic        mem_we;

   logic [32:0] mem_q [Depth];

   assign rvalid_o = (count_q != '0) && (fifo_age_q[0] == AgeDone);
   assign pop      = rvalid_o;
   assign gnt_o    = req_i & ~stall & ((count_q < MaxCnt) | pop);
   assign push     = gnt_o;
   assign rdata_o  = rvalid_o ? fifo_rdata_q[0] : 33'h0;
   assign err_o    = rvalid_o & fifo_err_q[0];

   assign push_rdata = (in_range && !we_i) ? mem_q[idx] : 33'h0;
   assign push_err   = ~in_range;
   assign mem_we     = gnt_o & we_i & in_range & ~rst_i;

   always_comb begin
      for (int i = 0; i < MaxOutstanding; i++) begin
         aged[i] = (fifo_age_q[i] == AgeDone) ? fifo_age_q[i] : fifo_age_q[i] + AgeW'(1);
      end

      for (int i = 0; i < MaxOutstanding; i++) begin
         fifo_rdata_d[i] = fifo_rdata_q[i];
         fifo_err_d[i]   = fifo_err_q[i];
         fifo_age_d[i]   = aged[i];
      end

      if (pop) begin
         for (int i = 0; i < MaxOutstanding - 1; i++) begin
            fifo_rdata_d[i] = fifo_rdata_q[i+1];
            fifo_err_d[i]   = fifo_err_q[i+1];
            fifo_age_d[i]   = aged[i+1];
         end
      end

      wr_pos = count_q - CntW'(pop);

      // The grant cycle counts as the entry's first cycle of age, so the
      // entry lands with age 1 and reaches RespLatency exactly on time.
      for (int i = 0; i < MaxOutstanding; i++) begin
         if (push && (CntW'(i) == wr_pos)) begin
            fifo_rdata_d[i] = push_rdata;
            fifo_err_d[i]   = push_err;
            fifo_age_d[i]   = AgeW'(1);
         end
      end

      count_d = count_q + CntW'(push) - CntW'(pop);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
         for (int i = 0; i < MaxOutstanding; i++) begin
            fifo_rdata_q[i] <= 33'h0;
            fifo_err_q[i]   <= 1'b0;
            fifo_age_q[i]   <= '0;
         end
      end else begin
         count_q <= count_d;
         for (int i = 0; i < MaxOutstanding; i++) begin
            fifo_rdata_q[i] <= fifo_rdata_d[i];
            fifo_err_q[i]   <= fifo_err_d[i];
            fifo_age_q[i]   <= fifo_age_d[i];
         end
      end
   end

   // ------------------------------------------------------------------
   // Tagged SRAM, not reset. Partial writes clear the tag.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
               mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
         mem_q[idx][32] <= (be_i == 4'hF) ? wdata_i[32] : 1'b0;
      end
   end

endmodule
